// File: rtl/prim_onehot_grant_gen.sv
// Registered round-robin grant generator: offers one request lane at a time as an
// onehot/address/enable triple and holds it under a valid/ready handshake.
//
// state | meaning
// IDLE  | no offer pending; outputs are zero
// OFFER | oh_o/addr_o/valid_o hold the granted lane until handshake or flush
module prim_onehot_grant_gen #(
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned OneHotWidth = 2**AddrWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [OneHotWidth-1:0] req_i,
    input  logic                   flush_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [OneHotWidth-1:0] oh_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   en_o
);

    localparam logic [AddrWidth-1:0] LastLane = AddrWidth'(OneHotWidth - 1);
    localparam logic [AddrWidth:0]   NumLanes = (AddrWidth + 1)'(OneHotWidth);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   ptr_q, ptr_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [OneHotWidth-1:0] oh_q, oh_d;
    logic                   valid_q, valid_d;

    logic                   hs;
    logic [AddrWidth-1:0]   ptr_inc, ptr_arb;
    logic                   hi_vld, lo_vld, win_vld;
    logic [AddrWidth-1:0]   hi_idx, lo_idx, win_idx;

    // The pointer wraps at the real lane count, which need not be a power of two.
    assign ptr_inc = (addr_q == LastLane) ? '0 : addr_q + 1'b1;
    assign hs      = (state_q == OFFER) && ready_i;
    assign ptr_arb = hs ? ptr_inc : ptr_q;

    // Lowest request at or above the pointer wins; otherwise the lowest one below it.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int unsigned i = 0; i < OneHotWidth; i++) begin
            if (req_i[i]) begin
                if (AddrWidth'(i) >= ptr_arb) begin
                    if (!hi_vld) begin
                        hi_vld = 1'b1;
                        hi_idx = AddrWidth'(i);
                    end
                end else if (!lo_vld) begin
                    lo_vld = 1'b1;
                    lo_idx = AddrWidth'(i);
                end
            end
        end
        win_vld = hi_vld | lo_vld;
        win_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        oh_d    = oh_q;
        if (flush_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            addr_d  = '0;
            oh_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        state_d = OFFER;
                        valid_d = 1'b1;
                        addr_d  = win_idx;
                        oh_d    = OneHotWidth'(1) << win_idx;
                    end
                end
                OFFER: begin
                    if (ready_i) begin
                        ptr_d = ptr_inc;
                        if (win_vld) begin
                            valid_d = 1'b1;
                            addr_d  = win_idx;
                            oh_d    = OneHotWidth'(1) << win_idx;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            addr_d  = '0;
                            oh_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    addr_d  = '0;
                    oh_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            oh_q    <= oh_d;
        end
    end

    assign valid_o = valid_q;
    assign en_o    = valid_q;
    assign oh_o    = oh_q;
    assign addr_o  = addr_q;

`ifndef SYNTHESIS
    a_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(oh_o));
    a_or_en   : assert property (@(posedge clk_i) disable iff (!rst_ni) (|oh_o) == en_o);
    a_en_vld  : assert property (@(posedge clk_i) disable iff (!rst_ni) en_o == valid_o);
    a_range   : assert property (@(posedge clk_i) disable iff (!rst_ni) {1'b0, addr_o} < NumLanes);
    a_addr_oh : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 valid_o |-> oh_o[addr_o]);
    a_idle_0  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 !valid_o |-> (oh_o == '0 && addr_o == '0));
    a_stable  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 (valid_o && !ready_i && !flush_i) |=>
                                 ($stable(oh_o) && $stable(addr_o) && $stable(valid_o)));
`endif

endmodule

// File: tb/tb_prim_onehot_grant_gen.sv
// Bench for prim_onehot_grant_gen: 32-lane and 5-lane instances checked against a
// scan-based round-robin model, with directed vectors and constrained-random traffic.
module tb_prim_onehot_grant_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] req_b, oh_b;
    logic        rdy_b, fl_b, valid_b, en_b;
    logic [4:0]  addr_b;
    logic [4:0]  req_s, oh_s;
    logic        rdy_s, fl_s, valid_s, en_s;
    logic [2:0]  addr_s;

    prim_onehot_grant_gen #(.AddrWidth(5)) u_dut_big (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .flush_i(fl_b), .ready_i(rdy_b),
        .valid_o(valid_b), .oh_o(oh_b), .addr_o(addr_b), .en_o(en_b)
    );

    prim_onehot_grant_gen #(.AddrWidth(3), .OneHotWidth(5)) u_dut_small (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_s), .flush_i(fl_s), .ready_i(rdy_s),
        .valid_o(valid_s), .oh_o(oh_s), .addr_o(addr_s), .en_o(en_s)
    );

    typedef struct {
        bit          valid;
        int unsigned addr;
        int unsigned ptr;
    } mstate_t;

    typedef struct {
        logic [31:0] req;
        bit          rdy;
        bit          fl;
        bit          ev;
        int unsigned ea;
    } vec_t;

    mstate_t mb, ms;
    int      n_cmp = 0;
    int      n_err = 0;
    vec_t    tbl[11];

    function automatic int unsigned winner(logic [31:0] req, int unsigned ptr, int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned idx = (ptr + k) % n;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic mstate_t mstep(mstate_t s, logic [31:0] req, logic rdy, logic fl,
                                      int unsigned n);
        mstate_t r = s;
        if (fl) begin
            r.valid = 1'b0;
            r.addr  = 0;
        end else if (!s.valid) begin
            if (req != 0) begin
                r.valid = 1'b1;
                r.addr  = winner(req, s.ptr, n);
            end
        end else if (rdy) begin
            r.ptr = (s.addr + 1) % n;
            if (req != 0) r.addr = winner(req, r.ptr, n);
            else begin
                r.valid = 1'b0;
                r.addr  = 0;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_oh(mstate_t s);
        return s.valid ? (32'd1 << s.addr) : 32'd0;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_models();
        check("big_valid", {31'd0, valid_b}, {31'd0, mb.valid});
        check("big_en", {31'd0, en_b}, {31'd0, mb.valid});
        check("big_addr", {27'd0, addr_b}, mb.addr);
        check("big_oh", oh_b, exp_oh(mb));
        check("small_valid", {31'd0, valid_s}, {31'd0, ms.valid});
        check("small_en", {31'd0, en_s}, {31'd0, ms.valid});
        check("small_addr", {29'd0, addr_s}, ms.addr);
        check("small_oh", {27'd0, oh_s}, exp_oh(ms));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mb = mstep(mb, req_b, rdy_b, fl_b, 32);
        ms = mstep(ms, {27'd0, req_s}, rdy_s, fl_s, 5);
        check_models();
    endtask

    task automatic idle_inputs();
        req_b = '0; rdy_b = 1'b0; fl_b = 1'b0;
        req_s = '0; rdy_s = 1'b0; fl_s = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        mb = '{1'b0, 0, 0};
        ms = '{1'b0, 0, 0};
        #1;
        check_models();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{32'h0000_0008, 1'b0, 1'b0, 1'b1, 3};
        tbl[1]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 3};
        tbl[2]  = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 3};
        tbl[3]  = '{32'h0000_0001, 1'b1, 1'b0, 1'b1, 0};
        tbl[4]  = '{32'h0000_0030, 1'b1, 1'b0, 1'b1, 4};
        tbl[5]  = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 0};
        tbl[6]  = '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 0};
        tbl[7]  = '{32'h8000_0000, 1'b0, 1'b0, 1'b1, 31};
        tbl[8]  = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 0};
        tbl[9]  = '{32'h0000_0040, 1'b1, 1'b1, 1'b0, 0};
        tbl[10] = '{32'h0000_0041, 1'b0, 1'b0, 1'b1, 0};

        idle_inputs();
        rst_n = 1'b0;
        mb = '{1'b0, 0, 0};
        ms = '{1'b0, 0, 0};
        #12;
        check_models();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            req_b = tbl[i].req;
            rdy_b = tbl[i].rdy;
            fl_b  = tbl[i].fl;
            step();
            check("tbl_valid", {31'd0, valid_b}, {31'd0, tbl[i].ev});
            check("tbl_addr", {27'd0, addr_b}, tbl[i].ea);
        end

        // Single request then held offer while requests are gone.
        do_reset();
        req_b = 32'h8;
        step();
        check("hold_first_oh", oh_b, 32'h8);
        req_b = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_addr", {27'd0, addr_b}, 3);
            check("hold_valid", {31'd0, valid_b}, 1);
        end

        // Full request vector with constant ready: one grant per cycle, no bubble.
        do_reset();
        req_b = '1;
        rdy_b = 1'b1;
        for (int i = 0; i < 33; i++) begin
            step();
            check("sweep_addr", {27'd0, addr_b}, i % 32);
            check("sweep_valid", {31'd0, valid_b}, 1);
        end

        // Flush beats a simultaneous handshake and leaves the pointer alone.
        do_reset();
        req_b = 32'h20;
        step();
        req_b = 32'h40;
        rdy_b = 1'b1;
        step();
        check("flush_pre_addr", {27'd0, addr_b}, 6);
        req_b = '1;
        fl_b  = 1'b1;
        step();
        check("flush_valid", {31'd0, valid_b}, 0);
        check("flush_oh", oh_b, 0);
        check("flush_addr", {27'd0, addr_b}, 0);
        fl_b  = 1'b0;
        rdy_b = 1'b0;
        step();
        check("flush_regrant", {27'd0, addr_b}, 6);

        // Asynchronous reset in the middle of an offer.
        do_reset();
        req_b = 32'h200;
        step();
        check("rst_pre_addr", {27'd0, addr_b}, 9);
        req_b = '1;
        #3 rst_n = 1'b0;
        mb = '{1'b0, 0, 0};
        ms = '{1'b0, 0, 0};
        #1;
        check("async_valid", {31'd0, valid_b}, 0);
        check("async_oh", oh_b, 0);
        check("async_addr", {27'd0, addr_b}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_addr", {27'd0, addr_b}, 0);

        // Non-power-of-two lane count: pointer wraps at 5.
        do_reset();
        req_s = 5'b10001;
        rdy_s = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("np2_addr", {29'd0, addr_s}, (i % 2 == 1) ? 4 : 0);
            check("np2_oh_range", {31'd0, oh_s <= 5'h10}, 1);
        end

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) req_b = '0;
            else req_b = $urandom & $urandom & $urandom;
            rdy_b = ($urandom_range(0, 3) != 0);
            fl_b  = ($urandom_range(0, 15) == 0);
            req_s = 5'($urandom & $urandom);
            rdy_s = ($urandom_range(0, 2) != 0);
            fl_s  = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
